// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flag bit positions.
package seq_alu_pkg;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSrl  = 4'b0100;
  localparam logic [3:0] OpSra  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpMulu = 4'b1001;
  localparam logic [3:0] OpDivu = 4'b1010;
  localparam logic [3:0] OpNor  = 4'b1100;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam int unsigned FlagZero = 0;
  localparam int unsigned FlagOvf  = 1;
  localparam int unsigned FlagDz   = 2;
  localparam int unsigned FlagErr  = 3;
  localparam int unsigned NumFlags = 4;

  localparam logic ModeMul = 1'b0;
  localparam logic ModeDiv = 1'b1;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and, with SEQ_ALU_DIV_EN, restoring divide.
// lo/hi present the values after the current step so the caller can capture them with done.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, q_q, opd_q;
  logic [WIDTH-1:0] lo_step, hi_step;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;

  assign addend  = q_q[0] ? opd_q : '0;
  assign mul_sum = {1'b0, acc_q} + {1'b0, addend};

`ifdef SEQ_ALU_DIV_EN
  logic           mode_q;
  logic [WIDTH:0] shifted, trial;

  assign shifted = {acc_q, q_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, opd_q};

  always_comb begin
    lo_step = {mul_sum[0], q_q[WIDTH-1:1]};
    hi_step = mul_sum[WIDTH:1];
    if (mode_q == ModeDiv) begin
      // Top bit of trial set means the shifted remainder was below the divisor.
      if (!trial[WIDTH]) begin
        hi_step = trial[WIDTH-1:0];
        lo_step = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = shifted[WIDTH-1:0];
        lo_step = {q_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= ModeMul;
    end else if (start) begin
      mode_q <= mode;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    lo_step = {mul_sum[0], q_q[WIDTH-1:1]};
    hi_step = mul_sum[WIDTH:1];
  end
`endif

  assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign lo   = lo_step;
  assign hi   = hi_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      opd_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= a;
      opd_q  <= b;
    end else if (busy_q) begin
      acc_q  <= hi_step;
      q_q    <= lo_step;
      cnt_q  <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops plus iterative MULU/DIVU.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise DIVU is an illegal op.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             err
);

  state_e              state_q;
  logic [WIDTH-1:0]    result_q, hi_q;
  logic [NumFlags-1:0] flags_q;

  logic [WIDTH-1:0]    alu_res, alu_hi, sum, diff;
  logic [NumFlags-1:0] alu_flags, md_flags;
  logic [CNT_W-2:0]    shamt;
  logic                use_md, accept, md_start, md_done, md_mode;
  logic [WIDTH-1:0]    md_lo, md_hi;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[CNT_W-2:0];

  always_comb begin
    alu_res   = '0;
    alu_hi    = '0;
    alu_flags = '0;
    use_md    = 1'b0;
    case (op)
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpNor:  alu_res = ~(a | b);
      OpAdd: begin
        alu_res            = sum;
        alu_flags[FlagOvf] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res            = diff;
        alu_flags[FlagOvf] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OpSll:  alu_res = a << shamt;
      OpSrl:  alu_res = a >> shamt;
      OpSra:  alu_res = $signed(a) >>> shamt;
      OpMulu: use_md = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OpDivu: begin
        // Divide-by-zero bypasses the iterative path entirely.
        if (b == '0) begin
          alu_res           = '1;
          alu_hi            = a;
          alu_flags[FlagDz] = 1'b1;
        end else begin
          use_md = 1'b1;
        end
      end
`endif
      default: alu_flags[FlagErr] = 1'b1;
    endcase
    alu_flags[FlagZero] = (alu_res == '0);
  end

  always_comb begin
    md_flags           = '0;
    md_flags[FlagZero] = (md_lo == '0);
  end

  assign accept   = in_valid && (state_q == StIdle);
  assign md_start = accept && use_md;
  assign md_mode  = (op == OpDivu) ? ModeDiv : ModeMul;

  seq_alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .mode  (md_mode),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (use_md) begin
              state_q <= StBusy;
            end else begin
              state_q  <= StDone;
              result_q <= alu_res;
              hi_q     <= alu_hi;
              flags_q  <= alu_flags;
            end
          end
        end
        StBusy: begin
          if (md_done) begin
            state_q  <= StDone;
            result_q <= md_lo;
            hi_q     <= md_hi;
            flags_q  <= md_flags;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = flags_q[FlagZero];
  assign ovf       = flags_q[FlagOvf];
  assign err       = flags_q[FlagErr];

`ifdef SEQ_ALU_DIV_EN
  assign dz = flags_q[FlagDz];
`else
  logic unused_dz;
  assign unused_dz = flags_q[FlagDz];
  assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32; DIVU expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, ovf, dz, err;
  logic [W-1:0] result, hi;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .ovf       (ovf),
    .dz        (dz),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {zero, ovf, dz, err}.
  function automatic logic [3:0] flags();
    return {zero, ovf, dz, err};
  endfunction

  // Issue one request; lat counts falling edges after acceptance until out_valid.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output bit ready_seen);
    int guard = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready && !out_valid) ready_seen = 1'b1;
    end while (!out_valid && lat < 100);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t vecs[13] = '{
    '{OpAdd,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0100},
    '{OpSub,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000},
    '{OpSlt,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000},
    '{OpSltu, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000},
    '{OpAnd,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0000},
    '{OpOr,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b0000},
    '{OpNor,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000},
    '{OpSll,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 4'b0000},
    '{OpSrl,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4'b0000},
    '{OpSra,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b0000},
    '{OpSub,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0100},
    '{OpAdd,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000},
    '{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1001}
  };

  initial begin
    int  lat;
    bit  rs;
    bit  seen;

    repeat (3) @(negedge clk);
    check("rst_low.out_valid", 64'(out_valid), 64'd0);
    check("rst_low.result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.flags", 64'(flags()), 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rs);
      check($sformatf("vec%0d.lat", i), 64'(lat), 64'd1);
      check($sformatf("vec%0d.result", i), 64'(result), 64'(vecs[i].res));
      check($sformatf("vec%0d.hi", i), 64'(hi), 64'd0);
      check($sformatf("vec%0d.flags", i), 64'(flags()), 64'(vecs[i].flg));
      drain();
    end

    run_op(OpMulu, 32'hFFFF_FFFF, 32'h2, lat, rs);
    check("mulu1.lat", 64'(lat), 64'd33);
    check("mulu1.in_ready_low", 64'(rs), 64'd0);
    check("mulu1.result", 64'(result), 64'hFFFF_FFFE);
    check("mulu1.hi", 64'(hi), 64'd1);
    check("mulu1.flags", 64'(flags()), 64'd0);
    drain();

    run_op(OpMulu, 32'h1234_5678, 32'h100, lat, rs);
    check("mulu2.result", 64'(result), 64'h3456_7800);
    check("mulu2.hi", 64'(hi), 64'h12);
    drain();

    run_op(OpDivu, 32'd100, 32'd7, lat, rs);
`ifdef SEQ_ALU_DIV_EN
    check("divu.lat", 64'(lat), 64'd33);
    check("divu.result", 64'(result), 64'd14);
    check("divu.hi", 64'(hi), 64'd2);
    check("divu.flags", 64'(flags()), 64'd0);
`else
    check("divu.lat", 64'(lat), 64'd1);
    check("divu.result", 64'(result), 64'd0);
    check("divu.flags", 64'(flags()), 64'b1001);
`endif
    drain();

    run_op(OpDivu, 32'd100, 32'd0, lat, rs);
    check("divz.lat", 64'(lat), 64'd1);
`ifdef SEQ_ALU_DIV_EN
    check("divz.result", 64'(result), 64'hFFFF_FFFF);
    check("divz.hi", 64'(hi), 64'd100);
    check("divz.flags", 64'(flags()), 64'b0010);
`else
    check("divz.result", 64'(result), 64'd0);
    check("divz.flags", 64'(flags()), 64'b1001);
`endif
    drain();

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    op = OpMulu; a = 32'd5; b = 32'd6; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.result", 64'(result), 64'd0);
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.flags", 64'(flags()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst.no_valid", 64'(seen), 64'd0);
    run_op(OpAdd, 32'd3, 32'd4, lat, rs);
    check("postrst.lat", 64'(lat), 64'd1);
    check("postrst.result", 64'(result), 64'd7);
    drain();

    // Hold in DONE with a pending request that must be taken afterwards.
    run_op(OpAdd, 32'd1, 32'd2, lat, rs);
    op = OpOr; a = 32'hF0; b = 32'h0F; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d.result", k), 64'(result), 64'd3);
      check($sformatf("hold%0d.in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("hold%0d.out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d.flags", k), 64'(flags()), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("pend.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pend.out_valid", 64'(out_valid), 64'd1);
    check("pend.result", 64'(result), 64'hFF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  4  operation code (encoding per REQ-012).
REQ-008 a, b  input  WIDTH  operands.
REQ-009 out_valid  output  1  result available; out_ready  input  1  consumer accepts.
REQ-010 result  output  WIDTH  primary result; hi  output  WIDTH  upper product / remainder.
REQ-011 zero, ovf, dz, err  output  1 each  flags (result==0, signed overflow, divide-by-zero, illegal op).

Function
REQ-012 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1100 NOR, 0011 SLL, 0100 SRL, 0101 SRA (shift amount b[CNT_W-2:0]), 1001 MULU, 1010 DIVU; all others illegal.
REQ-013 FSM states IDLE, BUSY, DONE; transfer on in = in_valid && in_ready, transfer on out = out_valid && out_ready.
REQ-014 in_ready = 1 only in IDLE; operands and op are captured on the input transfer.
REQ-015 Single-cycle ops and illegal ops: IDLE -> DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-016 MULU/DIVU: IDLE -> BUSY; exactly WIDTH iterations, one per cycle; BUSY -> DONE after the last; out_valid WIDTH+1 cycles after acceptance.
REQ-017 MULU: unsigned shift-add; {hi,result} = full 2*WIDTH-bit product.
REQ-018 DIVU: unsigned restoring division; result = quotient, hi = remainder.
REQ-019 DIVU with b==0: skip BUSY (latency 1); result all-ones, hi = a, dz=1.
REQ-020 In DONE, result/hi/flags are held stable until the output transfer; DONE -> IDLE on the output transfer.
REQ-021 zero = (result==0) for every op, including MULU (low half) and DIVU.
REQ-022 ovf meaningful for ADD/SUB only (signed two's-complement overflow); 0 for all other ops.
REQ-023 Illegal op: result=0, hi=0, err=1, zero=1.
REQ-024 hi = 0 for every op other than MULU/DIVU.
REQ-025 ADD/SUB results wrap modulo 2^WIDTH.
REQ-026 A request presented while not IDLE is not accepted and is not lost; it is accepted once the block returns to IDLE.

Reset
REQ-027 rst_n low forces IDLE immediately, including mid-BUSY; the in-flight operation is discarded.
REQ-028 Reset values: in_ready=1 once rst_n is high, out_valid=0, result=0, hi=0, zero=0, ovf=0, dz=0, err=0, iteration counter 0.

Configuration
REQ-029 Macro SEQ_ALU_DIV_EN defined: DIVU is implemented per REQ-016/018/019.
REQ-030 SEQ_ALU_DIV_EN undefined: no divider logic; 1010 is treated as illegal per REQ-023; dz is tied 0; MULU is unaffected.

Structure
REQ-031 Package seq_alu_pkg holds the op-code constants, the FSM state typedef (IDLE/BUSY/DONE) and the flag-bit positions.
REQ-032 The iterative multiply/divide datapath is implemented in sub-module seq_alu_muldiv (start, mode, a, b -> done, lo, hi).
REQ-033 The single-cycle ops and the FSM remain in seq_alu.

Verification (WIDTH=32)
REQ-034 ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1, zero=0, out_valid 1 cycle after acceptance.
REQ-035 SUB a=5, b=5 -> result 0, zero=1, ovf=0; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-036 MULU a=0xFFFFFFFF, b=2 -> hi=1, result=0xFFFFFFFE, out_valid exactly 33 cycles after acceptance; in_ready=0 throughout.
REQ-037 DIVU a=100, b=7 -> result 14, hi 2; DIVU b=0 -> result 0xFFFFFFFF, hi=100, dz=1, latency 1; with the macro undefined -> err=1.
REQ-038 MULU accepted, rst_n pulsed low at cycle 10 -> out_valid never rises for that op, all outputs 0, next ADD 3+4 returns 7.
REQ-039 Hold out_ready=0 for 5 cycles in DONE -> result/flags stable and in_ready=0; illegal op 1111 -> err=1, result 0.
